envm_fault_store: RTL and testbench
===================================

ENVM_FAULT_STORE -- requirements
Module: envm_fault_store

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- SYSTOLIC_SIZE, 8, array dimension
- WEIGHT_WIDTH, 8, weight bits
- ACTIVATION_WIDTH, 8, activation bits
- ADDR_WIDTH, $clog2(SYSTOLIC_SIZE), fault row address bits
- PARTIAL_SUM_WIDTH, WEIGHT_WIDTH+ACTIVATION_WIDTH+$clog2(SYSTOLIC_SIZE), psum bits
- SA_TEST_PATTERN_DEPTH, 12, stuck-at pattern count
- TD_TEST_PATTERN_DEPTH, 18, transition-delay pattern count
- MAX_PATTERN_ADDR_WIDTH, $clog2(max of the two depths), counter bits
- READ_LATENCY, 2, pattern read pipeline stages (>=1)
- PROG_CYCLES, 4, NVM program duration (>=1)

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock
- rst_n, in, 1, asynchronous active-low reset
- rd_req, in, 1, pattern read request
- test_type, in, 1, 0 SA, 1 TD
- TD_answer_choose, in, 1, 0 launch, 1 capture
- test_counter, in, MAX_PATTERN_ADDR_WIDTH, pattern index
- rd_valid, out, 1, read data valid
- rd_err, out, 1, index out of range, qualified by rd_valid
- Scan_data_weight, out, WEIGHT_WIDTH
- Scan_data_activation, out, ACTIVATION_WIDTH
- Scan_data_partial_sum_in, out, PARTIAL_SUM_WIDTH
- Scan_data_answer, out, PARTIAL_SUM_WIDTH
- detection_en, in, 1, program request
- detection_addr, in, ADDR_WIDTH, fault row address
- merge_mode, in, 1, 0 overwrite, 1 OR-accumulate
- single_pe_detection / column_fault_detection / row_fault_detection, in, SYSTOLIC_SIZE each
- clear_req, in, 1, erase all fault storage
- prog_busy, out, 1, program in progress
- drop_flag, out, 1, sticky: a request was lost
- envm_faulty_patterns_flat, out, SYSTOLIC_SIZE*SYSTOLIC_SIZE, row i at [i*SYSTOLIC_SIZE +: SYSTOLIC_SIZE]
- faulty_row, faulty_column, out, SYSTOLIC_SIZE each
- fault_count, out, $clog2(SYSTOLIC_SIZE*SYSTOLIC_SIZE+1), popcount of the flat map

Function
REQ-003 Pattern arrays SHALL keep the existing SA and TD (weight_1/2, activation_1/2, psum_1/2, launch/capture answer) set. The bench loads them directly. They are never reset or written by RTL.
REQ-004 Output mux SHALL be:
- TD weight = weight_2.
- TD_answer_choose=1 selects activation_1, psum_1 and the capture answer.
- TD_answer_choose=0 selects activation_2, psum_2 and the launch answer.
REQ-005 A read SHALL sample its inputs on the rd_req cycle. rd_valid and the data follow exactly READ_LATENCY cycles later. Back-to-back requests are accepted every cycle.
REQ-006 A test_counter at or above the selected depth SHALL return all-zero data with rd_err=1.
REQ-007 Scan outputs SHALL hold their last value while rd_valid=0.
REQ-008 The program FSM SHALL have states IDLE and PROG.
- IDLE to PROG on detection_en: latch addr, mode and the three vectors; prog_busy=1.
- PROG counts PROG_CYCLES cycles, commits on the last cycle, then returns to IDLE.
REQ-009 Commit with merge_mode=0 SHALL overwrite the addressed row and the row and column vectors. With merge_mode=1 it SHALL OR the new values into the stored values.
REQ-010 detection_en or clear_req arriving in PROG SHALL be ignored and SHALL set drop_flag.
REQ-011 clear_req in IDLE SHALL zero all fault storage in one cycle and SHALL have priority over a simultaneous detection_en, which is dropped and sets drop_flag.
REQ-012 fault_count SHALL be registered and SHALL update one cycle after any storage change.
REQ-013 drop_flag SHALL clear only on reset or an accepted clear_req.

Reset
REQ-014 Asserting rst_n low SHALL asynchronously force:
- FSM to IDLE, read pipeline empty;
- prog_busy, rd_valid, rd_err, drop_flag to 0;
- fault storage, scan outputs and fault_count to 0.
REQ-015 Reset during PROG SHALL abort with no commit.

Structure
REQ-016 A shared package SHALL hold the FSM state typedef and the depth/width constants.
REQ-017 One sub-module, envm_read_pipe, SHALL implement the READ_LATENCY valid/data shift stage.

Verification (SYSTOLIC_SIZE=8, READ_LATENCY=2, PROG_CYCLES=4)
REQ-018 Read SA idx 3 at cycle t gives rd_valid and SA_weight[3] at t+2. TD idx 5 with choose=1 returns capture_answer[5].
REQ-019 Read idx 12 SA gives zeros with rd_err=1. Idx 12 TD is legal, rd_err=0.
REQ-020 Program addr 2, pe=8'h81, overwrite: prog_busy for 4 cycles, flat[23:16]=8'h81, fault_count=2 one cycle later.
REQ-021 Merge 8'h06 into addr 2 gives 8'h87 and fault_count=4. A detection_en during PROG is ignored and sets drop_flag=1.
REQ-022 clear_req with detection_en in IDLE zeros the map, fault_count=0 and drop_flag=1. A later lone clear_req gives drop_flag=0.
REQ-023 rst_n low at PROG cycle 2 leaves the map unchanged (all zero) and prog_busy=0 immediately.

Source files
------------

// File: rtl/envm_fault_store_pkg.sv
// Shared types and default constants for the eNVM fault store.
package envm_fault_store_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PROG = 1'b1
  } prog_state_t;

  localparam int DEF_SYSTOLIC_SIZE = 8;
  localparam int DEF_WEIGHT_WIDTH  = 8;
  localparam int DEF_ACT_WIDTH     = 8;
  localparam int DEF_SA_DEPTH      = 12;
  localparam int DEF_TD_DEPTH      = 18;
  localparam int DEF_READ_LATENCY  = 2;
  localparam int DEF_PROG_CYCLES   = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/envm_read_pipe.sv
// Fixed-latency valid/data shift stage. Data registers only load when the
// stage feeding them is valid, so the final stage holds its last value.
module envm_read_pipe #(
  parameter int READ_LATENCY = 2,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_vld,
  input  logic [DATA_W-1:0] i_dat,
  output logic              o_vld,
  output logic [DATA_W-1:0] o_dat
);

  logic [READ_LATENCY:1]             r_vld_pipe;
  logic [READ_LATENCY:1][DATA_W-1:0] r_dat_pipe;

  // Shift valid every cycle; advance data only behind a valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_dat_pipe <= '0;
    end else begin
      r_vld_pipe[1] <= i_vld;
      if (i_vld) r_dat_pipe[1] <= i_dat;
      for (int k = 2; k <= READ_LATENCY; k++) begin
        r_vld_pipe[k] <= r_vld_pipe[k-1];
        if (r_vld_pipe[k-1]) r_dat_pipe[k] <= r_dat_pipe[k-1];
      end
    end
  end

  assign o_vld = r_vld_pipe[READ_LATENCY];
  assign o_dat = r_dat_pipe[READ_LATENCY];

endmodule

// File: rtl/envm_fault_store.sv
// eNVM model: scan-pattern read port plus programmable fault map storage.
module envm_fault_store
  import envm_fault_store_pkg::*;
#(
  parameter int SYSTOLIC_SIZE          = DEF_SYSTOLIC_SIZE,
  parameter int WEIGHT_WIDTH           = DEF_WEIGHT_WIDTH,
  parameter int ACTIVATION_WIDTH       = DEF_ACT_WIDTH,
  parameter int ADDR_WIDTH             = $clog2(SYSTOLIC_SIZE),
  parameter int PARTIAL_SUM_WIDTH      = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE),
  parameter int SA_TEST_PATTERN_DEPTH  = DEF_SA_DEPTH,
  parameter int TD_TEST_PATTERN_DEPTH  = DEF_TD_DEPTH,
  parameter int MAX_PATTERN_ADDR_WIDTH = $clog2(max2(SA_TEST_PATTERN_DEPTH, TD_TEST_PATTERN_DEPTH)),
  parameter int READ_LATENCY           = DEF_READ_LATENCY,
  parameter int PROG_CYCLES            = DEF_PROG_CYCLES
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   rd_req,
  input  logic                                   test_type,
  input  logic                                   TD_answer_choose,
  input  logic [MAX_PATTERN_ADDR_WIDTH-1:0]      test_counter,
  output logic                                   rd_valid,
  output logic                                   rd_err,
  output logic [WEIGHT_WIDTH-1:0]                Scan_data_weight,
  output logic [ACTIVATION_WIDTH-1:0]            Scan_data_activation,
  output logic [PARTIAL_SUM_WIDTH-1:0]           Scan_data_partial_sum_in,
  output logic [PARTIAL_SUM_WIDTH-1:0]           Scan_data_answer,
  input  logic                                   detection_en,
  input  logic [ADDR_WIDTH-1:0]                  detection_addr,
  input  logic                                   merge_mode,
  input  logic [SYSTOLIC_SIZE-1:0]               single_pe_detection,
  input  logic [SYSTOLIC_SIZE-1:0]               column_fault_detection,
  input  logic [SYSTOLIC_SIZE-1:0]               row_fault_detection,
  input  logic                                   clear_req,
  output logic                                   prog_busy,
  output logic                                   drop_flag,
  output logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE-1:0] envm_faulty_patterns_flat,
  output logic [SYSTOLIC_SIZE-1:0]               faulty_row,
  output logic [SYSTOLIC_SIZE-1:0]               faulty_column,
  output logic [$clog2(SYSTOLIC_SIZE*SYSTOLIC_SIZE+1)-1:0] fault_count
);

  localparam int FC_W   = $clog2(SYSTOLIC_SIZE*SYSTOLIC_SIZE+1);
  localparam int PC_W   = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;
  localparam int DATA_W = 1 + WEIGHT_WIDTH + ACTIVATION_WIDTH + 2*PARTIAL_SUM_WIDTH;

  // Scan pattern contents, preloaded externally; the RTL only reads them.
  logic [WEIGHT_WIDTH-1:0]      SA_weight          [SA_TEST_PATTERN_DEPTH];
  logic [ACTIVATION_WIDTH-1:0]  SA_activation      [SA_TEST_PATTERN_DEPTH];
  logic [PARTIAL_SUM_WIDTH-1:0] SA_partial_sum_in  [SA_TEST_PATTERN_DEPTH];
  logic [PARTIAL_SUM_WIDTH-1:0] SA_answer          [SA_TEST_PATTERN_DEPTH];
  logic [WEIGHT_WIDTH-1:0]      TD_weight_1        [TD_TEST_PATTERN_DEPTH];
  logic [WEIGHT_WIDTH-1:0]      TD_weight_2        [TD_TEST_PATTERN_DEPTH];
  logic [ACTIVATION_WIDTH-1:0]  TD_activation_1    [TD_TEST_PATTERN_DEPTH];
  logic [ACTIVATION_WIDTH-1:0]  TD_activation_2    [TD_TEST_PATTERN_DEPTH];
  logic [PARTIAL_SUM_WIDTH-1:0] TD_partial_sum_in_1[TD_TEST_PATTERN_DEPTH];
  logic [PARTIAL_SUM_WIDTH-1:0] TD_partial_sum_in_2[TD_TEST_PATTERN_DEPTH];
  logic [PARTIAL_SUM_WIDTH-1:0] TD_launch_answer   [TD_TEST_PATTERN_DEPTH];
  logic [PARTIAL_SUM_WIDTH-1:0] TD_capture_answer  [TD_TEST_PATTERN_DEPTH];

  logic                         w_err;
  logic [WEIGHT_WIDTH-1:0]      w_weight;
  logic [ACTIVATION_WIDTH-1:0]  w_act;
  logic [PARTIAL_SUM_WIDTH-1:0] w_psum;
  logic [PARTIAL_SUM_WIDTH-1:0] w_ans;
  logic                         w_pipe_vld;
  logic [DATA_W-1:0]            w_pipe_dat;
  logic                         w_pipe_err;

  // Pattern select on the request cycle; out-of-range indices read as zero.
  always_comb begin
    w_weight = '0;
    w_act    = '0;
    w_psum   = '0;
    w_ans    = '0;
    w_err    = test_type ? (32'(test_counter) >= TD_TEST_PATTERN_DEPTH)
                         : (32'(test_counter) >= SA_TEST_PATTERN_DEPTH);
    if (!w_err) begin
      if (!test_type) begin
        w_weight = SA_weight[test_counter];
        w_act    = SA_activation[test_counter];
        w_psum   = SA_partial_sum_in[test_counter];
        w_ans    = SA_answer[test_counter];
      end else begin
        // Transition-delay always scans weight_2; choose picks the half.
        w_weight = TD_weight_2[test_counter];
        if (TD_answer_choose) begin
          w_act  = TD_activation_1[test_counter];
          w_psum = TD_partial_sum_in_1[test_counter];
          w_ans  = TD_capture_answer[test_counter];
        end else begin
          w_act  = TD_activation_2[test_counter];
          w_psum = TD_partial_sum_in_2[test_counter];
          w_ans  = TD_launch_answer[test_counter];
        end
      end
    end
  end

  envm_read_pipe #(
    .READ_LATENCY (READ_LATENCY),
    .DATA_W       (DATA_W)
  ) u_read_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .i_vld (rd_req),
    .i_dat ({w_err, w_weight, w_act, w_psum, w_ans}),
    .o_vld (w_pipe_vld),
    .o_dat (w_pipe_dat)
  );

  assign {w_pipe_err, Scan_data_weight, Scan_data_activation,
          Scan_data_partial_sum_in, Scan_data_answer} = w_pipe_dat;
  assign rd_valid = w_pipe_vld;
  assign rd_err   = w_pipe_vld & w_pipe_err;

  // ---------------- program path ----------------
  prog_state_t                      r_state, w_state_next;
  logic [PC_W-1:0]                  r_prog_cnt;
  logic [ADDR_WIDTH-1:0]            r_addr;
  logic                             r_mode;
  logic [SYSTOLIC_SIZE-1:0]         r_pe, r_col, r_row;
  logic [SYSTOLIC_SIZE-1:0][SYSTOLIC_SIZE-1:0] r_map;
  logic [SYSTOLIC_SIZE-1:0]         r_faulty_row, r_faulty_col;
  logic                             r_drop;
  logic [FC_W-1:0]                  r_fault_count, w_pop;
  logic                             w_accept, w_commit, w_clear, w_drop;

  // Next state and strobes; clear beats a same-cycle program request.
  always_comb begin
    w_state_next = r_state;
    prog_busy    = 1'b0;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    w_clear      = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (clear_req) begin
          w_clear = 1'b1;
          w_drop  = detection_en;
        end else if (detection_en) begin
          w_accept     = 1'b1;
          w_state_next = ST_PROG;
        end
      end
      ST_PROG: begin
        prog_busy = 1'b1;
        w_drop    = detection_en | clear_req;
        if (r_prog_cnt == PC_W'(PROG_CYCLES-1)) begin
          w_commit     = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Latch the request on acceptance and count the program duration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prog_cnt <= '0;
      r_addr     <= '0;
      r_mode     <= 1'b0;
      r_pe       <= '0;
      r_col      <= '0;
      r_row      <= '0;
    end else if (w_accept) begin
      r_prog_cnt <= '0;
      r_addr     <= detection_addr;
      r_mode     <= merge_mode;
      r_pe       <= single_pe_detection;
      r_col      <= column_fault_detection;
      r_row      <= row_fault_detection;
    end else if (r_state == ST_PROG) begin
      r_prog_cnt <= r_prog_cnt + 1'b1;
    end
  end

  // Fault storage: bulk clear or commit (overwrite or OR-merge).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_map        <= '0;
      r_faulty_row <= '0;
      r_faulty_col <= '0;
    end else if (w_clear) begin
      r_map        <= '0;
      r_faulty_row <= '0;
      r_faulty_col <= '0;
    end else if (w_commit) begin
      r_map[r_addr] <= r_mode ? (r_map[r_addr] | r_pe)  : r_pe;
      r_faulty_row  <= r_mode ? (r_faulty_row  | r_row) : r_row;
      r_faulty_col  <= r_mode ? (r_faulty_col  | r_col) : r_col;
    end
  end

  // Sticky lost-request flag; a dropped request wins over the clearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_drop <= 1'b0;
    else if (w_drop)  r_drop <= 1'b1;
    else if (w_clear) r_drop <= 1'b0;
  end

  // Population count of the map, registered one cycle behind storage.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < SYSTOLIC_SIZE*SYSTOLIC_SIZE; i++)
      w_pop = w_pop + FC_W'(envm_faulty_patterns_flat[i]);
  end

  // Registered fault count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fault_count <= '0;
    else        r_fault_count <= w_pop;
  end

  assign envm_faulty_patterns_flat = r_map;
  assign faulty_row                = r_faulty_row;
  assign faulty_column             = r_faulty_col;
  assign drop_flag                 = r_drop;
  assign fault_count               = r_fault_count;

endmodule

// File: tb/tb_envm_fault_store.sv
// Directed bench for envm_fault_store (S=8, READ_LATENCY=2, PROG_CYCLES=4).
module tb_envm_fault_store;

  localparam int S  = 8;
  localparam int P  = 19;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_req, test_type, TD_answer_choose;
  logic [CW-1:0] test_counter;
  logic          rd_valid, rd_err;
  logic [7:0]    Scan_data_weight, Scan_data_activation;
  logic [P-1:0]  Scan_data_partial_sum_in, Scan_data_answer;
  logic          detection_en, merge_mode, clear_req;
  logic [2:0]    detection_addr;
  logic [S-1:0]  single_pe_detection, column_fault_detection, row_fault_detection;
  logic          prog_busy, drop_flag;
  logic [S*S-1:0] envm_faulty_patterns_flat;
  logic [S-1:0]  faulty_row, faulty_column;
  logic [6:0]    fault_count;

  int n_checks = 0;
  int n_fail   = 0;

  envm_fault_store dut (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .test_type(test_type),
    .TD_answer_choose(TD_answer_choose), .test_counter(test_counter),
    .rd_valid(rd_valid), .rd_err(rd_err),
    .Scan_data_weight(Scan_data_weight), .Scan_data_activation(Scan_data_activation),
    .Scan_data_partial_sum_in(Scan_data_partial_sum_in), .Scan_data_answer(Scan_data_answer),
    .detection_en(detection_en), .detection_addr(detection_addr), .merge_mode(merge_mode),
    .single_pe_detection(single_pe_detection), .column_fault_detection(column_fault_detection),
    .row_fault_detection(row_fault_detection), .clear_req(clear_req),
    .prog_busy(prog_busy), .drop_flag(drop_flag),
    .envm_faulty_patterns_flat(envm_faulty_patterns_flat),
    .faulty_row(faulty_row), .faulty_column(faulty_column), .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic         tt;
    logic         ch;
    logic [CW-1:0] idx;
    logic         err;
    logic [7:0]   w;
    logic [7:0]   a;
    logic [P-1:0] p;
    logic [P-1:0] ans;
  } vec_t;

  vec_t vecs[9];

  task automatic prog(input logic [2:0] a, input logic m, input logic [S-1:0] pe,
                      input logic [S-1:0] col, input logic [S-1:0] row,
                      input logic poke, output int n);
    @(negedge clk);
    detection_en = 1'b1; detection_addr = a; merge_mode = m;
    single_pe_detection = pe; column_fault_detection = col; row_fault_detection = row;
    @(negedge clk);
    if (poke) begin
      // Second request while busy: must be ignored.
      detection_addr = 3'd5; single_pe_detection = 8'hFF;
      column_fault_detection = 8'hFF; row_fault_detection = 8'hFF;
    end else begin
      detection_en = 1'b0;
    end
    n = 0;
    while (prog_busy && n < 20) begin
      n++;
      @(negedge clk);
      detection_en = 1'b0;
    end
    if (n == 20) begin
      n_checks++; n_fail++;
      $display("FAIL prog_timeout: got busy after 20 cycles, expected idle");
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; rd_req = 0; test_type = 0; TD_answer_choose = 0; test_counter = '0;
    detection_en = 0; detection_addr = '0; merge_mode = 0; clear_req = 0;
    single_pe_detection = '0; column_fault_detection = '0; row_fault_detection = '0;

    for (int i = 0; i < 12; i++) begin
      dut.SA_weight[i]         = 8'(8'h10 + i);
      dut.SA_activation[i]     = 8'(8'h20 + i);
      dut.SA_partial_sum_in[i] = P'(19'h100 + i);
      dut.SA_answer[i]         = P'(19'h4000 + i);
    end
    for (int i = 0; i < 18; i++) begin
      dut.TD_weight_1[i]         = 8'(8'h30 + i);
      dut.TD_weight_2[i]         = 8'(8'h40 + i);
      dut.TD_activation_1[i]     = 8'(8'h50 + i);
      dut.TD_activation_2[i]     = 8'(8'h60 + i);
      dut.TD_partial_sum_in_1[i] = P'(19'h200 + i);
      dut.TD_partial_sum_in_2[i] = P'(19'h300 + i);
      dut.TD_launch_answer[i]    = P'(19'h5000 + i);
      dut.TD_capture_answer[i]   = P'(19'h6000 + i);
    end

    vecs[0] = '{1'b0, 1'b0, 5'd3,  1'b0, 8'h13, 8'h23, 19'h00103, 19'h04003};
    vecs[1] = '{1'b1, 1'b1, 5'd5,  1'b0, 8'h45, 8'h55, 19'h00205, 19'h06005};
    vecs[2] = '{1'b1, 1'b0, 5'd5,  1'b0, 8'h45, 8'h65, 19'h00305, 19'h05005};
    vecs[3] = '{1'b0, 1'b0, 5'd12, 1'b1, 8'h00, 8'h00, 19'h00000, 19'h00000};
    vecs[4] = '{1'b1, 1'b1, 5'd12, 1'b0, 8'h4C, 8'h5C, 19'h0020C, 19'h0600C};
    vecs[5] = '{1'b0, 1'b1, 5'd11, 1'b0, 8'h1B, 8'h2B, 19'h0010B, 19'h0400B};
    vecs[6] = '{1'b1, 1'b0, 5'd17, 1'b0, 8'h51, 8'h71, 19'h00311, 19'h05011};
    vecs[7] = '{1'b1, 1'b1, 5'd18, 1'b1, 8'h00, 8'h00, 19'h00000, 19'h00000};
    vecs[8] = '{1'b0, 1'b0, 5'd0,  1'b0, 8'h10, 8'h20, 19'h00100, 19'h04000};

    // Reset state
    #12;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_err", rd_err, 0);
    chk("rst_prog_busy", prog_busy, 0);
    chk("rst_drop", drop_flag, 0);
    chk("rst_flat", envm_faulty_patterns_flat, 0);
    chk("rst_count", fault_count, 0);
    chk("rst_weight", Scan_data_weight, 0);
    chk("rst_answer", Scan_data_answer, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back read table; each result lands two cycles after issue.
    for (int k = 0; k < 11; k++) begin
      if (k == 1) chk("lat_not_early", rd_valid, 0);
      if (k >= 2) begin
        chk($sformatf("v%0d_valid", k-2), rd_valid, 1);
        chk($sformatf("v%0d_err", k-2), rd_err, vecs[k-2].err);
        chk($sformatf("v%0d_weight", k-2), Scan_data_weight, vecs[k-2].w);
        chk($sformatf("v%0d_act", k-2), Scan_data_activation, vecs[k-2].a);
        chk($sformatf("v%0d_psum", k-2), Scan_data_partial_sum_in, vecs[k-2].p);
        chk($sformatf("v%0d_ans", k-2), Scan_data_answer, vecs[k-2].ans);
      end
      if (k < 9) begin
        rd_req = 1'b1; test_type = vecs[k].tt;
        TD_answer_choose = vecs[k].ch; test_counter = vecs[k].idx;
      end else begin
        rd_req = 1'b0; test_counter = 5'd7;
      end
      @(negedge clk);
    end
    chk("hold_valid", rd_valid, 0);
    chk("hold_err", rd_err, 0);
    chk("hold_weight", Scan_data_weight, 8'h10);
    chk("hold_psum", Scan_data_partial_sum_in, 19'h00100);

    // Overwrite program of row 2
    prog(3'd2, 1'b0, 8'h81, 8'h01, 8'h04, 1'b0, n);
    chk("p1_busy_cycles", n, 4);
    chk("p1_row2", envm_faulty_patterns_flat[23:16], 8'h81);
    chk("p1_faulty_row", faulty_row, 8'h04);
    chk("p1_faulty_col", faulty_column, 8'h01);
    chk("p1_count_lag", fault_count, 0);
    @(negedge clk);
    chk("p1_count", fault_count, 2);
    chk("p1_drop", drop_flag, 0);

    // Merge into row 2 with a second request during PROG
    prog(3'd2, 1'b1, 8'h06, 8'h02, 8'h04, 1'b1, n);
    chk("p2_busy_cycles", n, 4);
    chk("p2_row2", envm_faulty_patterns_flat[23:16], 8'h87);
    chk("p2_row5", envm_faulty_patterns_flat[47:40], 8'h00);
    chk("p2_faulty_row", faulty_row, 8'h04);
    chk("p2_faulty_col", faulty_column, 8'h03);
    chk("p2_drop", drop_flag, 1);
    @(negedge clk);
    chk("p2_count", fault_count, 4);

    // Clear with simultaneous detection_en
    clear_req = 1'b1; detection_en = 1'b1; detection_addr = 3'd1; single_pe_detection = 8'hFF;
    @(negedge clk);
    clear_req = 1'b0; detection_en = 1'b0;
    chk("c1_flat", envm_faulty_patterns_flat, 0);
    chk("c1_row", faulty_row, 0);
    chk("c1_col", faulty_column, 0);
    chk("c1_drop", drop_flag, 1);
    chk("c1_busy", prog_busy, 0);
    chk("c1_count_lag", fault_count, 4);
    @(negedge clk);
    chk("c1_count", fault_count, 0);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    chk("c2_drop", drop_flag, 0);

    // Reset during PROG cycle 2
    detection_en = 1'b1; detection_addr = 3'd1; merge_mode = 1'b0;
    single_pe_detection = 8'hFF; column_fault_detection = 8'hFF; row_fault_detection = 8'hFF;
    @(negedge clk);
    detection_en = 1'b0;
    @(negedge clk);
    chk("r_busy_before", prog_busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("r_busy_async", prog_busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("r_flat", envm_faulty_patterns_flat, 0);
    chk("r_count", fault_count, 0);
    chk("r_busy", prog_busy, 0);
    chk("r_col", faulty_column, 0);
    chk("r_weight_cleared", Scan_data_weight, 0);

    // Pattern contents survive reset
    rd_req = 1'b1; test_type = 1'b0; test_counter = 5'd3;
    @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
    chk("r_read_valid", rd_valid, 1);
    chk("r_read_weight", Scan_data_weight, 8'h13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
